x_pcie_rx_credit_ret: RTL and testbench
=======================================

Name: x_pcie_rx_credit_ret

Overview:
- Sits directly downstream of the x_pcie_core VC0 receive interface.
- Parses every received TLP header: fmt/type from word 0, length from word 1.
- Returns the consumed receive-buffer credits to the core via ph/pd/nph/npd_processed_vc0, with pd_num_vc0/npd_num_vc0.
- Optionally holds those returns until user logic releases each packet, and reports buffer pressure through the *_buf_status_vc0 inputs of the core.

Parameters:
- HOLD_DEPTH, 8, entries in the pending-return queue (RX_CREDIT_HOLD_EN only); power of 2, ≥4.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- sys_clk_125  in  1  125 MHz core clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- dl_up  in  1  data link up from core.
- rx_data_vc0  in  16  receive data.
- rx_st_vc0  in  1  first word of TLP.
- rx_end_vc0  in  1  last word of TLP.
- rx_us_req_vc0  in  1  unsupported-request flag, valid with rx_end_vc0.
- rx_malf_tlp_vc0  in  1  malformed-TLP flag, valid with rx_end_vc0.
- pkt_release  in  1  user has finished with oldest held TLP (used only with RX_CREDIT_HOLD_EN).
- ph_processed_vc0  out  1  one-cycle pulse: one posted header returned.
- pd_processed_vc0  out  1  one-cycle pulse: pd_num_vc0 posted data credits returned.
- nph_processed_vc0  out  1  non-posted header returned.
- npd_processed_vc0  out  1  non-posted data returned (always 1 credit).
- pd_num_vc0  out  8  posted data credits; 0 encodes 256.
- npd_num_vc0  out  8  non-posted data credits (constant 1 when pulsing).
- ph_buf_status_vc0, pd_buf_status_vc0, nph_buf_status_vc0, npd_buf_status_vc0  out  1 each  hold-queue almost-full.
- proto_err  out  1  one-cycle pulse on stream framing error.
- tlp_cnt  out  CNT_W  saturating count of completed TLPs.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; queue empty; counters 0.
- FSM states and transitions:
  - IDLE: rx_st → capture fmt = data[14:13], type = data[12:8] → HDR1.
  - HDR1: capture len = data[9:0] → BODY.
  - BODY: rx_end → finalise → IDLE.
- Classification:
  - Posted: type[4:3] = 2'b10 (Msg/MsgD), or type = 5'b00000 with fmt[1] = 1 (MWr).
  - Non-posted: MRd/MRdLk (type 0000x, fmt[1] = 0), IO (00010), Cfg (0010x).
  - Completions (01010/01011) and any other type: no credit return.
- Data present when fmt[1] = 1.
- Posted data credits = ceil(len/4); len = 0 means 1024 DW → 256 → pd_num 8'd0.
- Finalise: on the rx_end cycle, form a return record {ph, pd, nph, npd, pd_num}. Without hold, the pulses are registered and appear exactly 1 cycle after rx_end. ph and pd pulse in the same cycle for MWr; nph and npd in the same cycle for IOWr/CfgWr.
- rx_us_req/rx_malf on the rx_end cycle do not suppress the return; the core buffer is consumed regardless.
- rx_end while in HDR1 (truncated header): proto_err pulses, no return, → IDLE.
- rx_st while in HDR1 or BODY: proto_err pulses; the current TLP is dropped without return; the header is recaptured → HDR1.
- rx_st and rx_end in the same cycle while in IDLE: proto_err pulses, stay in IDLE.
- dl_up low: FSM forced to IDLE next cycle; queue flushed; no pulses issued while dl_up = 0.
- tlp_cnt increments on each finalise (every completed TLP, returning or not) and saturates at all-ones.
- num outputs hold their last value between pulses; they are only valid with their pulse.

Optional Feature:
- Macro RX_CREDIT_HOLD_EN.
- Defined:
  - Return records are pushed into a HOLD_DEPTH FIFO (completions push an empty record to keep ordering).
  - Each pkt_release pops one record; the pulses appear 1 cycle after the pop.
  - pkt_release on an empty queue is ignored.
  - Push and pop in the same cycle keep the count unchanged.
  - All four buf_status outputs = (count ≥ HOLD_DEPTH-1).
  - A push when full is dropped and pulses proto_err.
- Undefined: no FIFO; pkt_release ignored; buf_status outputs constant 0.

Decomposition:
- Package x_pcie_rx_pkg:
  - fmt/type localparams (TYPE_MEM, TYPE_IO, TYPE_CFG0/1, TYPE_CPL, TYPE_MSG_PFX).
  - FSM state encoding (IDLE/HDR1/BODY).
  - Return-record struct (ph, pd, nph, npd, pd_num[7:0]).
- One sub-module: x_pcie_ret_fifo, a sync FIFO with count output, instantiated only under RX_CREDIT_HOLD_EN.

Test Plan:
- MWr len = 8 DW, 10 words rx_st→rx_end → 1 cycle after rx_end: ph = 1, pd = 1, pd_num = 2; tlp_cnt = 1.
- MWr len = 0 (1024 DW) → pd_num = 0 with pd pulse; MWr len = 5 → pd_num = 2.
- MRd then CfgWr0 back-to-back → nph pulse; then nph + npd, npd_num = 1; CplD → no pulse, tlp_cnt = 3.
- rx_st mid-BODY → proto_err pulse, first TLP no return, second TLP returns normally; rx_end in HDR1 → proto_err, no return.
- HOLD_DEPTH = 8, hold enabled: 7 MWr with no release → buf_status = 1 after the 7th; 3 pkt_release pulses → 3 ph pulses, buf_status = 0; 9 pushes with no release → proto_err on the 9th.
- Drop dl_up mid-TLP with the queue holding 4 records → no pulses, queue empty, next TLP after dl_up = 1 handled normally; rst_n asserted mid-BODY → all outputs 0 immediately.

Source files
------------

// File: rtl/x_pcie_rx_pkg.sv
// x_pcie_rx_pkg: shared definitions for the VC0 receive credit-return block.
//   - TLP fmt/type code points used to classify received headers
//   - receive-FSM state encoding
//   - credit return record and helpers that build it from a parsed header
package x_pcie_rx_pkg;

  localparam logic [4:0] TYPE_MEM     = 5'b00000;  // MRd / MWr
  localparam logic [4:0] TYPE_MEM_LK  = 5'b00001;  // MRdLk
  localparam logic [4:0] TYPE_IO      = 5'b00010;
  localparam logic [4:0] TYPE_CFG0    = 5'b00100;
  localparam logic [4:0] TYPE_CFG1    = 5'b00101;
  localparam logic [4:0] TYPE_CPL     = 5'b01010;  // Cpl/CplD, bit 0 selects the locked variant
  localparam logic [1:0] TYPE_MSG_PFX = 2'b10;     // type[4:3] of Msg/MsgD
  localparam int unsigned FMT_DATA_BIT = 1;        // fmt bit that flags a data payload

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR1 = 2'd1,
    BODY = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic       ph;
    logic       pd;
    logic       nph;
    logic       npd;
    logic [7:0] pd_num;
  } ret_rec_t;

  localparam int unsigned REC_W = $bits(ret_rec_t);

  // Posted data credits are 4 DW each; a length field of 0 means 1024 DW, which gives
  // 256 credits and therefore wraps to the 8'd0 encoding on the credit interface.
  function automatic logic [7:0] pd_credits(input logic [9:0] len);
    logic [10:0] dw;
    dw = (len == 10'd0) ? 11'd1024 : {1'b0, len};
    return 8'((dw + 11'd3) >> 2);
  endfunction

  function automatic ret_rec_t classify(input logic has_data, input logic [4:0] typ,
                                        input logic [9:0] len);
    ret_rec_t rec;
    logic     is_cpl;
    logic     posted;
    logic     non_posted;
    is_cpl     = (typ[4:1] == TYPE_CPL[4:1]);
    posted     = (typ[4:3] == TYPE_MSG_PFX) || ((typ == TYPE_MEM) && has_data);
    non_posted = (((typ == TYPE_MEM) || (typ == TYPE_MEM_LK)) && !has_data) ||
                 (typ == TYPE_IO) || (typ == TYPE_CFG0) || (typ == TYPE_CFG1);
    rec        = '0;
    if (!is_cpl) begin
      rec.ph  = posted;
      rec.pd  = posted && has_data;
      rec.nph = non_posted;
      rec.npd = non_posted && has_data;
      if (posted && has_data) begin
        rec.pd_num = pd_credits(len);
      end
    end
    return rec;
  endfunction

endpackage

// File: rtl/x_pcie_ret_fifo.sv
// x_pcie_ret_fifo: small synchronous FIFO holding credit return records until release.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         empties the queue (takes priority over push/pop)
//   push, wdata   write request and record
//   pop, rdata    read request and head-of-queue record (valid when not empty)
//   count         entries held; full / empty flags
// A push while full is accepted only when a pop frees a slot in the same cycle.
module x_pcie_ret_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 12,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/x_pcie_rx_credit_ret.sv
// x_pcie_rx_credit_ret: parses each TLP on the core's VC0 receive stream and returns the
// consumed receive-buffer credits through the *_processed_vc0 / *_num_vc0 interface.
// Optional feature macro: RX_CREDIT_HOLD_EN -- return records are queued and released one
// per pkt_release; buffer-status outputs report queue almost-full. Without it, returns
// pulse one cycle after rx_end_vc0, pkt_release is ignored and buffer status is 0.
// Ports:
//   sys_clk_125, rst_n          clock, asynchronous active-low reset
//   dl_up                       link up; low forces IDLE, flushes the queue, mutes pulses
//   rx_data_vc0, rx_st_vc0,     receive stream (word 0: fmt/type, word 1: length)
//   rx_end_vc0, rx_us_req_vc0,
//   rx_malf_tlp_vc0
//   pkt_release                 user done with oldest held TLP
//   ph/pd/nph/npd_processed_vc0 one-cycle credit return pulses
//   pd_num_vc0, npd_num_vc0     data credit counts, valid with their pulse
//   *_buf_status_vc0            hold queue almost-full
//   proto_err                   one-cycle pulse on framing error or queue overflow
//   tlp_cnt                     saturating count of completed TLPs
module x_pcie_rx_credit_ret
  import x_pcie_rx_pkg::*;
#(
  parameter int unsigned HOLD_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             sys_clk_125,
  input  logic             rst_n,
  input  logic             dl_up,
  input  logic [15:0]      rx_data_vc0,
  input  logic             rx_st_vc0,
  input  logic             rx_end_vc0,
  input  logic             rx_us_req_vc0,
  input  logic             rx_malf_tlp_vc0,
  input  logic             pkt_release,
  output logic             ph_processed_vc0,
  output logic             pd_processed_vc0,
  output logic             nph_processed_vc0,
  output logic             npd_processed_vc0,
  output logic [7:0]       pd_num_vc0,
  output logic [7:0]       npd_num_vc0,
  output logic             ph_buf_status_vc0,
  output logic             pd_buf_status_vc0,
  output logic             nph_buf_status_vc0,
  output logic             npd_buf_status_vc0,
  output logic             proto_err,
  output logic [CNT_W-1:0] tlp_cnt
);

  rx_state_e state_q;
  logic [1:0] fmt_q;
  logic [4:0] type_q;
  logic [9:0] len_q;

  ret_rec_t fin_rec;
  ret_rec_t out_rec;
  logic     finalise;
  logic     frame_err;
  logic     queue_err;
  logic     almost_full;

  // The core buffer is consumed even for UR/malformed TLPs, so those flags don't matter.
  logic unused_in;
  assign unused_in = ^{rx_us_req_vc0, rx_malf_tlp_vc0, rx_data_vc0[15], fmt_q[0]};

  always_comb begin
    fin_rec = classify(fmt_q[FMT_DATA_BIT], type_q, len_q);
  end

  // Framing checks; rx_st always wins so a new header is never lost.
  always_comb begin
    finalise  = 1'b0;
    frame_err = 1'b0;
    if (dl_up) begin
      case (state_q)
        IDLE:    frame_err = rx_st_vc0 && rx_end_vc0;
        HDR1:    frame_err = rx_st_vc0 || rx_end_vc0;
        BODY: begin
          frame_err = rx_st_vc0;
          finalise  = rx_end_vc0 && !rx_st_vc0;
        end
        default: frame_err = 1'b0;
      endcase
    end
  end

`ifdef RX_CREDIT_HOLD_EN
  localparam int unsigned QCNT_W = $clog2(HOLD_DEPTH) + 1;

  logic [REC_W-1:0]  q_rdata;
  logic [QCNT_W-1:0] q_count;
  logic              q_full;
  logic              q_empty;
  logic              q_pop;

  assign q_pop = dl_up && pkt_release && !q_empty;

  x_pcie_ret_fifo #(
    .DEPTH (HOLD_DEPTH),
    .WIDTH (REC_W)
  ) u_ret_fifo (
    .clk   (sys_clk_125),
    .rst_n (rst_n),
    .flush (!dl_up),
    .push  (finalise),
    .wdata (fin_rec),
    .pop   (q_pop),
    .rdata (q_rdata),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  // Completions push an all-zero record, so ordering against pkt_release is preserved.
  always_comb begin
    out_rec = '0;
    if (q_pop) out_rec = ret_rec_t'(q_rdata);
  end

  assign queue_err   = finalise && q_full && !q_pop;
  assign almost_full = (q_count >= QCNT_W'(HOLD_DEPTH - 1));
`else
  logic unused_hold;
  assign unused_hold = ^{pkt_release, HOLD_DEPTH};

  always_comb begin
    out_rec = '0;
    if (finalise) out_rec = fin_rec;
  end

  assign queue_err   = 1'b0;
  assign almost_full = 1'b0;
`endif

  assign ph_buf_status_vc0  = almost_full;
  assign pd_buf_status_vc0  = almost_full;
  assign nph_buf_status_vc0 = almost_full;
  assign npd_buf_status_vc0 = almost_full;

  always_ff @(posedge sys_clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      fmt_q             <= '0;
      type_q            <= '0;
      len_q             <= '0;
      ph_processed_vc0  <= 1'b0;
      pd_processed_vc0  <= 1'b0;
      nph_processed_vc0 <= 1'b0;
      npd_processed_vc0 <= 1'b0;
      pd_num_vc0        <= '0;
      npd_num_vc0       <= '0;
      proto_err         <= 1'b0;
      tlp_cnt           <= '0;
    end else begin
      ph_processed_vc0  <= out_rec.ph;
      pd_processed_vc0  <= out_rec.pd;
      nph_processed_vc0 <= out_rec.nph;
      npd_processed_vc0 <= out_rec.npd;
      // Counts hold between pulses.
      if (out_rec.pd)  pd_num_vc0  <= out_rec.pd_num;
      if (out_rec.npd) npd_num_vc0 <= 8'd1;
      proto_err <= frame_err || queue_err;
      if (finalise && (tlp_cnt != '1)) tlp_cnt <= tlp_cnt + CNT_W'(1);

      if (!dl_up) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (rx_st_vc0 && !rx_end_vc0) begin
              fmt_q   <= rx_data_vc0[14:13];
              type_q  <= rx_data_vc0[12:8];
              state_q <= HDR1;
            end
          end
          HDR1: begin
            if (rx_st_vc0) begin
              fmt_q   <= rx_data_vc0[14:13];
              type_q  <= rx_data_vc0[12:8];
            end else if (rx_end_vc0) begin
              state_q <= IDLE;
            end else begin
              len_q   <= rx_data_vc0[9:0];
              state_q <= BODY;
            end
          end
          BODY: begin
            if (rx_st_vc0) begin
              fmt_q   <= rx_data_vc0[14:13];
              type_q  <= rx_data_vc0[12:8];
              state_q <= HDR1;
            end else if (rx_end_vc0) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_x_pcie_rx_credit_ret.sv
// Testbench for x_pcie_rx_credit_ret. Default build checks immediate credit returns;
// with RX_CREDIT_HOLD_EN defined it checks the hold queue instead.
module tb_x_pcie_rx_credit_ret;

  localparam int unsigned CNT_W = 6;

  logic             clk;
  logic             rst_n;
  logic             dl_up;
  logic [15:0]      rx_data;
  logic             rx_st;
  logic             rx_end;
  logic             rx_us;
  logic             rx_malf;
  logic             pkt_release;
  logic             ph, pd, nph, npd;
  logic [7:0]       pd_num, npd_num;
  logic             ph_bs, pd_bs, nph_bs, npd_bs;
  logic             proto_err;
  logic [CNT_W-1:0] tlp_cnt;

  int checks;
  int failures;
  int n_ph, n_pd, n_nph, n_npd, n_perr;

  x_pcie_rx_credit_ret #(
    .HOLD_DEPTH (8),
    .CNT_W      (CNT_W)
  ) dut (
    .sys_clk_125        (clk),
    .rst_n              (rst_n),
    .dl_up              (dl_up),
    .rx_data_vc0        (rx_data),
    .rx_st_vc0          (rx_st),
    .rx_end_vc0         (rx_end),
    .rx_us_req_vc0      (rx_us),
    .rx_malf_tlp_vc0    (rx_malf),
    .pkt_release        (pkt_release),
    .ph_processed_vc0   (ph),
    .pd_processed_vc0   (pd),
    .nph_processed_vc0  (nph),
    .npd_processed_vc0  (npd),
    .pd_num_vc0         (pd_num),
    .npd_num_vc0        (npd_num),
    .ph_buf_status_vc0  (ph_bs),
    .pd_buf_status_vc0  (pd_bs),
    .nph_buf_status_vc0 (nph_bs),
    .npd_buf_status_vc0 (npd_bs),
    .proto_err          (proto_err),
    .tlp_cnt            (tlp_cnt)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // Pulse totals, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      n_ph   <= n_ph + int'(ph);
      n_pd   <= n_pd + int'(pd);
      n_nph  <= n_nph + int'(nph);
      n_npd  <= n_npd + int'(npd);
      n_perr <= n_perr + int'(proto_err);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] fmt;
    logic [4:0] typ;
    logic [9:0] len;
    int         nw;
    logic       us;
    logic [3:0] exp_ret;     // {ph, pd, nph, npd}
    logic [7:0] exp_pd_num;
    logic [7:0] exp_npd_num;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] hdr0(input logic [1:0] fmt, input logic [4:0] typ);
    return {1'b0, fmt, typ, 8'h00};
  endfunction

  function automatic logic [3:0] rets();
    return {ph, pd, nph, npd};
  endfunction

  function automatic logic [3:0] bstat();
    return {ph_bs, pd_bs, nph_bs, npd_bs};
  endfunction

  // Drive one stream word and wait to the next falling edge.
  task automatic word(input logic st, input logic en, input logic [15:0] d);
    rx_st   = st;
    rx_end  = en;
    rx_data = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_st   = 1'b0;
    rx_end  = 1'b0;
    rx_us   = 1'b0;
    rx_malf = 1'b0;
    rx_data = 16'h0;
    repeat (n) @(negedge clk);
  endtask

  // Full TLP; returns at the falling edge after the rx_end cycle.
  task automatic send(input logic [1:0] fmt, input logic [4:0] typ, input logic [9:0] len,
                      input int nw, input logic us);
    for (int i = 0; i < nw; i++) begin
      rx_us   = us && (i == nw - 1);
      rx_malf = us && (i == nw - 1);
      if (i == 0)      word(1'b1, 1'b0, hdr0(fmt, typ));
      else if (i == 1) word(1'b0, (i == nw - 1), {6'b0, len});
      else             word(1'b0, (i == nw - 1), 16'hA5A5 ^ 16'(i));
    end
    rx_us   = 1'b0;
    rx_malf = 1'b0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    dl_up       = 1'b1;
    pkt_release = 1'b0;
    idle(2);
    chk("reset_rets", 32'(rets()), 32'h0);
    chk("reset_nums", {16'h0, pd_num, npd_num}, 32'h0);
    chk("reset_cnt", 32'(tlp_cnt), 32'h0);
    chk("reset_perr_bs", {27'h0, proto_err, bstat()}, 32'h0);
    rst_n = 1'b1;
    idle(1);
  endtask

`ifndef RX_CREDIT_HOLD_EN
  task automatic run_default();
    vec_t v[19];
    int   e_ph, e_pd, e_nph, e_npd, p0, perr0;
    v[0]  = '{2'b10, 5'b00000, 10'd8,    10, 1'b0, 4'b1100, 8'd2,   8'd0};  // MWr 8DW
    v[1]  = '{2'b10, 5'b00000, 10'd0,     6, 1'b0, 4'b1100, 8'd0,   8'd0};  // MWr 1024DW
    v[2]  = '{2'b10, 5'b00000, 10'd5,     5, 1'b1, 4'b1100, 8'd2,   8'd0};  // MWr 5DW, UR
    v[3]  = '{2'b00, 5'b00000, 10'd1,     3, 1'b0, 4'b0010, 8'd2,   8'd0};  // MRd
    v[4]  = '{2'b10, 5'b00100, 10'd1,     4, 1'b0, 4'b0011, 8'd2,   8'd1};  // CfgWr0
    v[5]  = '{2'b10, 5'b01010, 10'd4,     6, 1'b0, 4'b0000, 8'd2,   8'd1};  // CplD
    v[6]  = '{2'b11, 5'b10000, 10'd2,     4, 1'b0, 4'b1100, 8'd1,   8'd1};  // MsgD
    v[7]  = '{2'b00, 5'b00010, 10'd1,     3, 1'b0, 4'b0010, 8'd1,   8'd1};  // IORd
    v[8]  = '{2'b11, 5'b00000, 10'd1023,  4, 1'b0, 4'b1100, 8'd0,   8'd1};  // MWr4 1023DW
    v[9]  = '{2'b01, 5'b10100, 10'd0,     3, 1'b0, 4'b1000, 8'd0,   8'd1};  // Msg
    v[10] = '{2'b00, 5'b00001, 10'd1,     3, 1'b0, 4'b0010, 8'd0,   8'd1};  // MRdLk
    v[11] = '{2'b10, 5'b00010, 10'd1,     4, 1'b0, 4'b0011, 8'd0,   8'd1};  // IOWr
    v[12] = '{2'b10, 5'b00000, 10'd4,     4, 1'b0, 4'b1100, 8'd1,   8'd1};  // MWr 4DW
    v[13] = '{2'b00, 5'b00101, 10'd1,     3, 1'b1, 4'b0010, 8'd1,   8'd1};  // CfgRd1, malf
    v[14] = '{2'b10, 5'b01011, 10'd4,     5, 1'b0, 4'b0000, 8'd1,   8'd1};  // CplDLk
    v[15] = '{2'b00, 5'b01010, 10'd0,     3, 1'b0, 4'b0000, 8'd1,   8'd1};  // Cpl
    v[16] = '{2'b11, 5'b10011, 10'd13,    5, 1'b0, 4'b1100, 8'd4,   8'd1};  // MsgD 13DW
    v[17] = '{2'b10, 5'b00000, 10'd1020,  4, 1'b0, 4'b1100, 8'd255, 8'd1};  // MWr 1020DW
    v[18] = '{2'b00, 5'b11100, 10'd1,     3, 1'b0, 4'b0000, 8'd255, 8'd1};  // reserved type

    e_ph = 0; e_pd = 0; e_nph = 0; e_npd = 0;
    // Back-to-back: each TLP starts on the edge its predecessor's return is checked.
    for (int i = 0; i < 19; i++) begin
      send(v[i].fmt, v[i].typ, v[i].len, v[i].nw, v[i].us);
      chk($sformatf("vec%0d_rets", i), 32'(rets()), 32'(v[i].exp_ret));
      chk($sformatf("vec%0d_pd_num", i), 32'(pd_num), 32'(v[i].exp_pd_num));
      chk($sformatf("vec%0d_npd_num", i), 32'(npd_num), 32'(v[i].exp_npd_num));
      chk($sformatf("vec%0d_cnt", i), 32'(tlp_cnt), 32'(i + 1));
      e_ph  += int'(v[i].exp_ret[3]);
      e_pd  += int'(v[i].exp_ret[2]);
      e_nph += int'(v[i].exp_ret[1]);
      e_npd += int'(v[i].exp_ret[0]);
    end
    idle(2);
    chk("one_cycle_ph", 32'(n_ph), 32'(e_ph));
    chk("one_cycle_pd", 32'(n_pd), 32'(e_pd));
    chk("one_cycle_nph", 32'(n_nph), 32'(e_nph));
    chk("one_cycle_npd", 32'(n_npd), 32'(e_npd));
    chk("no_perr_table", 32'(n_perr), 32'h0);
    chk("bs_zero", 32'(bstat()), 32'h0);

    // rx_st mid-BODY drops the first TLP; pkt_release must have no effect here.
    pkt_release = 1'b1;
    p0 = n_ph;
    word(1'b1, 1'b0, hdr0(2'b10, 5'b00000));
    word(1'b0, 1'b0, 16'd8);
    word(1'b0, 1'b0, 16'h1234);
    word(1'b1, 1'b0, hdr0(2'b00, 5'b00000));
    chk("restart_perr", 32'(proto_err), 32'h1);
    word(1'b0, 1'b0, 16'd1);
    word(1'b0, 1'b0, 16'h0);
    word(1'b0, 1'b1, 16'h0);
    chk("restart_second_ret", 32'(rets()), 32'b0010);
    chk("restart_cnt", 32'(tlp_cnt), 32'd20);
    pkt_release = 1'b0;
    idle(2);
    chk("restart_no_ph", 32'(n_ph), 32'(p0));
    chk("bs_zero_release", 32'(bstat()), 32'h0);

    // rx_end in HDR1: truncated header.
    word(1'b1, 1'b0, hdr0(2'b10, 5'b00000));
    word(1'b0, 1'b1, 16'd4);
    chk("trunc_perr", 32'(proto_err), 32'h1);
    chk("trunc_rets", 32'(rets()), 32'h0);
    idle(1);
    chk("trunc_cnt", 32'(tlp_cnt), 32'd20);
    send(2'b00, 5'b00000, 10'd1, 3, 1'b0);
    chk("after_trunc_ret", 32'(rets()), 32'b0010);
    chk("after_trunc_cnt", 32'(tlp_cnt), 32'd21);

    // rx_st with rx_end in IDLE stays in IDLE, so the following words are ignored.
    idle(1);
    perr0 = n_perr;
    word(1'b1, 1'b1, hdr0(2'b10, 5'b00000));
    chk("st_end_perr", 32'(proto_err), 32'h1);
    word(1'b0, 1'b0, 16'd4);
    word(1'b0, 1'b1, 16'h0);
    chk("st_end_no_ret", 32'(rets()), 32'h0);
    idle(2);
    chk("st_end_cnt", 32'(tlp_cnt), 32'd21);
    chk("st_end_perr_once", 32'(n_perr - perr0), 32'h1);

    // dl_up low mid-TLP: no return even with rx_end, FSM back in IDLE afterwards.
    word(1'b1, 1'b0, hdr0(2'b10, 5'b00000));
    word(1'b0, 1'b0, 16'd8);
    word(1'b0, 1'b0, 16'h0);
    dl_up = 1'b0;
    word(1'b0, 1'b1, 16'h0);
    chk("dl_down_no_ret", 32'(rets()), 32'h0);
    dl_up = 1'b1;
    word(1'b0, 1'b1, 16'h0);
    chk("dl_up_idle_no_ret", 32'(rets()), 32'h0);
    chk("dl_down_cnt", 32'(tlp_cnt), 32'd21);
    idle(1);
    send(2'b10, 5'b00000, 10'd8, 4, 1'b0);
    chk("dl_back_ret", 32'(rets()), 32'b1100);
    chk("dl_back_pd_num", 32'(pd_num), 32'd2);
    chk("dl_back_cnt", 32'(tlp_cnt), 32'd22);

    // Saturation of the statistics counter.
    for (int i = 0; i < 41; i++) send(2'b00, 5'b01010, 10'd0, 3, 1'b0);
    idle(1);
    chk("cnt_at_max", 32'(tlp_cnt), 32'd63);
    send(2'b00, 5'b01010, 10'd0, 3, 1'b0);
    send(2'b00, 5'b01010, 10'd0, 3, 1'b0);
    chk("cnt_saturated", 32'(tlp_cnt), 32'd63);

    // Asynchronous reset mid-BODY clears outputs without waiting for an edge.
    word(1'b1, 1'b0, hdr0(2'b10, 5'b00000));
    word(1'b0, 1'b0, 16'd8);
    word(1'b0, 1'b0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cnt", 32'(tlp_cnt), 32'h0);
    chk("async_rst_nums", {16'h0, pd_num, npd_num}, 32'h0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    send(2'b10, 5'b00000, 10'd8, 10, 1'b0);
    chk("post_rst_ret", 32'(rets()), 32'b1100);
    chk("post_rst_cnt", 32'(tlp_cnt), 32'd1);
  endtask
`else
  task automatic run_hold();
    // Seven held posted writes: almost-full only after the seventh.
    for (int i = 0; i < 7; i++) begin
      send(2'b10, 5'b00000, 10'd4, 3, 1'b0);
      if (i == 5) chk("hold_bs_after6", 32'(bstat()), 32'h0);
    end
    chk("hold_bs_after7", 32'(bstat()), 32'hF);
    idle(2);
    chk("hold_no_ph", 32'(n_ph), 32'h0);

    pkt_release = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold_release%0d_ret", i), 32'(rets()), 32'b1100);
    end
    pkt_release = 1'b0;
    chk("hold_pd_num", 32'(pd_num), 32'd1);
    chk("hold_bs_after_release", 32'(bstat()), 32'h0);
    idle(2);
    chk("hold_ph_total", 32'(n_ph), 32'd3);

    // Link drop with four records queued: flushed and silent.
    word(1'b1, 1'b0, hdr0(2'b10, 5'b00000));
    word(1'b0, 1'b0, 16'd4);
    dl_up = 1'b0;
    pkt_release = 1'b1;
    word(1'b0, 1'b0, 16'h0);
    chk("hold_dl_down_ret", 32'(rets()), 32'h0);
    dl_up = 1'b1;
    word(1'b0, 1'b1, 16'h0);
    chk("hold_empty_release", 32'(rets()), 32'h0);
    pkt_release = 1'b0;
    idle(2);
    chk("hold_flush_no_ph", 32'(n_ph), 32'd3);
    send(2'b10, 5'b00000, 10'd8, 4, 1'b0);
    chk("hold_dl_back_cnt", 32'(tlp_cnt), 32'd8);
    pkt_release = 1'b1;
    idle(1);
    pkt_release = 1'b0;
    chk("hold_dl_back_ret", 32'(rets()), 32'b1100);
    chk("hold_dl_back_pd_num", 32'(pd_num), 32'd2);

    // Nine pushes into an empty queue of eight: the ninth overflows.
    for (int i = 0; i < 9; i++) begin
      send(2'b10, 5'b00000, 10'd4, 3, 1'b0);
      if (i == 7) chk("hold_full_no_perr", 32'(proto_err), 32'h0);
    end
    chk("hold_overflow_perr", 32'(proto_err), 32'h1);
    chk("hold_full_bs", 32'(bstat()), 32'hF);

    // Push and pop in the same cycle while full: no overflow, count unchanged.
    word(1'b1, 1'b0, hdr0(2'b10, 5'b00000));
    word(1'b0, 1'b0, 16'd4);
    pkt_release = 1'b1;
    word(1'b0, 1'b1, 16'h0);
    chk("hold_pushpop_perr", 32'(proto_err), 32'h0);
    chk("hold_pushpop_ret", 32'(rets()), 32'b1100);
    rx_end = 1'b0;
    rx_st  = 1'b0;
    @(negedge clk);
    chk("hold_7_left_bs", 32'(bstat()), 32'hF);
    @(negedge clk);
    pkt_release = 1'b0;
    chk("hold_6_left_bs", 32'(bstat()), 32'h0);
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    n_ph = 0; n_pd = 0; n_nph = 0; n_npd = 0; n_perr = 0;
    rx_st = 1'b0; rx_end = 1'b0; rx_us = 1'b0; rx_malf = 1'b0; rx_data = 16'h0;
    do_reset();
`ifndef RX_CREDIT_HOLD_EN
    run_default();
`else
    run_hold();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
